fpga_cfg_loader: RTL and testbench



---
 rtl/fpga_cfg_pkg.sv | 34 +++
 rtl/fpga_cfg_loader_if.sv | 24 ++
 rtl/fpga_cfg_shadow.sv | 48 ++++
 rtl/fpga_cfg_loader.sv | 159 +++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared constants, loader state encoding and LUT payload layout for the fabric configuration loader.
// Optional feature macro used across the slice: CFG_CRC_EN (trailing XOR checksum word).
package fpga_cfg_pkg;

    localparam int unsigned NUM_LUT    = 8;
    localparam int unsigned NUM_SB     = 7;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned CFG_WORD_W = WORD_W;
    localparam int unsigned LUT_CFG_W  = 33;
    localparam int unsigned SB_CFG_W   = 32;

    // Image word positions
    localparam int unsigned LUT_BASE  = 0;
    localparam int unsigned SB_BASE   = 8;
    localparam int unsigned FLAG_IDX  = 15;
    localparam int unsigned CRC_IDX   = 16;
    localparam int unsigned IMG_WORDS = NUM_LUT + NUM_SB + 1;

    localparam int unsigned CNT_W = $clog2(IMG_WORDS + 1);
    localparam int unsigned IDX_W = $clog2(IMG_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } cfg_state_e;

    typedef struct packed {
        logic                  flop_sel;
        logic [CFG_WORD_W-1:0] bits;
    } lut_cfg_t;

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Configuration word stream: start pulse plus valid/ready data channel from host to loader.
interface fpga_cfg_loader_if;
    import fpga_cfg_pkg::*;

    logic                  cfg_start;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [CFG_WORD_W-1:0] cfg_data;

    modport master (
        output cfg_start,
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_start,
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );

endinterface

// File: rtl/fpga_cfg_shadow.sv
// Shadow register file for one configuration image, unpacked in parallel onto the LUT and switch-box buses.
module fpga_cfg_shadow
    import fpga_cfg_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          we_i,
    input  logic [IDX_W-1:0]              idx_i,
    input  logic [CFG_WORD_W-1:0]         data_i,
    output logic [NUM_LUT*LUT_CFG_W-1:0]  lut_o,
    output logic [NUM_SB*SB_CFG_W-1:0]    sb_o
);

    // Only the flop-select bits of the flag word are meaningful, so only those are kept
    logic [CFG_WORD_W-1:0] word_q [FLAG_IDX];
    logic [NUM_LUT-1:0]    flag_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < int'(FLAG_IDX); w++) begin
                word_q[w] <= '0;
            end
            flag_q <= '0;
        end else if (we_i) begin
            for (int w = 0; w < int'(FLAG_IDX); w++) begin
                if (idx_i == IDX_W'(w)) begin
                    word_q[w] <= data_i;
                end
            end
            if (idx_i == IDX_W'(FLAG_IDX)) begin
                flag_q <= data_i[CFG_WORD_W-1 -: NUM_LUT];
            end
        end
    end

    // LUT i takes its flop select from flag bit 31-i
    for (genvar i = 0; i < int'(NUM_LUT); i++) begin : g_lut
        lut_cfg_t ent;
        assign ent.flop_sel = flag_q[NUM_LUT-1-i];
        assign ent.bits     = word_q[LUT_BASE+i];
        assign lut_o[i*LUT_CFG_W +: LUT_CFG_W] = ent;
    end

    for (genvar j = 0; j < int'(NUM_SB); j++) begin : g_sb
        assign sb_o[j*SB_CFG_W +: SB_CFG_W] = word_q[SB_BASE+j];
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Fabric configuration loader: streams an image into a shadow file and commits it atomically.
// Build option CFG_CRC_EN adds a trailing XOR checksum word, a CHECK state and a sticky cfg_err.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset_n,
    fpga_cfg_loader_if.slave              cfg_if,
    output logic [NUM_LUT*LUT_CFG_W-1:0]  lut_cfg,
    output logic [NUM_SB*SB_CFG_W-1:0]    sb_cfg,
    output logic                          cfg_busy,
    output logic                          cfg_done,
    output logic                          cfg_err
);

    cfg_state_e                   state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         ready_q, busy_q, done_q;
    logic [NUM_LUT*LUT_CFG_W-1:0] lut_q;
    logic [NUM_SB*SB_CFG_W-1:0]   sb_q;
    logic                         wr_c, commit_c;
    logic [NUM_LUT*LUT_CFG_W-1:0] shadow_lut_c;
    logic [NUM_SB*SB_CFG_W-1:0]   shadow_sb_c;
`ifdef CFG_CRC_EN
    logic [CFG_WORD_W-1:0]        xor_q, xor_d;
    logic                         err_q, err_set_c, err_clr_c;
`endif

    fpga_cfg_shadow u_shadow (
        .clock   (clock),
        .reset_n (reset_n),
        .we_i    (wr_c),
        .idx_i   (IDX_W'(cnt_q)),
        .data_i  (cfg_if.cfg_data),
        .lut_o   (shadow_lut_c),
        .sb_o    (shadow_sb_c)
    );

    // Next-state, counter and checksum; a start pulse outranks any accept in the same cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_c     = 1'b0;
        commit_c = 1'b0;
`ifdef CFG_CRC_EN
        xor_d     = xor_q;
        err_set_c = 1'b0;
        err_clr_c = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_if.cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
`ifdef CFG_CRC_EN
                    xor_d     = '0;
                    err_clr_c = 1'b1;
`endif
                end
            end
            ST_LOAD: begin
                if (cfg_if.cfg_start) begin
                    cnt_d = '0;
`ifdef CFG_CRC_EN
                    xor_d     = '0;
                    err_clr_c = 1'b1;
`endif
                end else if (cfg_if.cfg_valid) begin
                    wr_c  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef CFG_CRC_EN
                    xor_d = xor_q ^ cfg_if.cfg_data;
`endif
                    if (cnt_q == CNT_W'(IMG_WORDS - 1)) begin
`ifdef CFG_CRC_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_COMMIT;
`endif
                    end
                end
            end
`ifdef CFG_CRC_EN
            // The checksum word is accepted here and compared against the running XOR
            ST_CHECK: begin
                if (cfg_if.cfg_start) begin
                    state_d   = ST_LOAD;
                    cnt_d     = '0;
                    xor_d     = '0;
                    err_clr_c = 1'b1;
                end else if (cfg_if.cfg_valid) begin
                    if (cfg_if.cfg_data == xor_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d   = ST_IDLE;
                        err_set_c = 1'b1;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                commit_c = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lut_q   <= '0;
            sb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= commit_c;
            if (commit_c) begin
                lut_q <= shadow_lut_c;
                sb_q  <= shadow_sb_c;
            end
        end
    end

`ifdef CFG_CRC_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xor_q <= '0;
            err_q <= 1'b0;
        end else begin
            xor_q <= xor_d;
            if (err_clr_c) begin
                err_q <= 1'b0;
            end else if (err_set_c) begin
                err_q <= 1'b1;
            end
        end
    end

    assign cfg_err = err_q;
`else
    assign cfg_err = 1'b0;
`endif

    assign cfg_if.cfg_ready = ready_q;
    assign lut_cfg          = lut_q;
    assign sb_cfg           = sb_q;
    assign cfg_busy         = busy_q;
    assign cfg_done         = done_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader: random images and gaps against a committed-image reference model.
module tb_fpga_cfg_loader;
    import fpga_cfg_pkg::*;

    localparam int unsigned LUT_BUS_W = NUM_LUT * LUT_CFG_W;
    localparam int unsigned SB_BUS_W  = NUM_SB * SB_CFG_W;
`ifdef CFG_CRC_EN
    localparam int unsigned SEND_W = IMG_WORDS + 1;
`else
    localparam int unsigned SEND_W = IMG_WORDS;
`endif

    typedef logic [LUT_BUS_W-1:0] chk_t;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [LUT_BUS_W-1:0] lut_cfg;
    logic [SB_BUS_W-1:0]  sb_cfg;
    logic                 cfg_busy;
    logic                 cfg_done;
    logic                 cfg_err;

    fpga_cfg_loader_if cfg_if ();

    fpga_cfg_loader dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cfg_if   (cfg_if),
        .lut_cfg  (lut_cfg),
        .sb_cfg   (sb_cfg),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    always #5 clock = ~clock;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_seen = 0;

    logic [CFG_WORD_W-1:0] img [SEND_W];
    logic [LUT_BUS_W-1:0]  exp_lut;
    logic [SB_BUS_W-1:0]   exp_sb;

    always @(negedge clock) begin
        if (cfg_done === 1'b1) done_seen++;
    end

    task automatic check_eq(input string tag, input chk_t obs, input chk_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_lut"}, chk_t'(lut_cfg), chk_t'(exp_lut));
        check_eq({tag, "_sb"}, chk_t'(sb_cfg), chk_t'(exp_sb));
    endtask

    // Reference: what the fabric must see once the current image is committed
    task automatic model_commit();
        for (int i = 0; i < int'(NUM_LUT); i++) begin
            exp_lut[i*LUT_CFG_W +: LUT_CFG_W] = {img[FLAG_IDX][31-i], img[LUT_BASE+i]};
        end
        for (int j = 0; j < int'(NUM_SB); j++) begin
            exp_sb[j*SB_CFG_W +: SB_CFG_W] = img[SB_BASE+j];
        end
    endtask

    task automatic seal_image();
`ifdef CFG_CRC_EN
        logic [CFG_WORD_W-1:0] x;
        x = '0;
        for (int i = 0; i < int'(IMG_WORDS); i++) x ^= img[i];
        img[CRC_IDX] = x;
`endif
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(IMG_WORDS); i++) img[i] = $urandom;
        seal_image();
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle before every word but the first, 2 random 0..2 idles
    task automatic do_load(input int gap_mode, input int abort_at, input bit bad_crc);
        int base_done;
        int gaps;
        base_done = done_seen;
        @(negedge clock);
        cfg_if.cfg_start = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        @(negedge clock);
        cfg_if.cfg_start = 1'b0;
        check_eq("ready_on_start", chk_t'(cfg_if.cfg_ready), chk_t'(1'b1));
        check_eq("busy_on_start", chk_t'(cfg_busy), chk_t'(1'b1));
        check_eq("err_clear_on_start", chk_t'(cfg_err), chk_t'(1'b0));
        if (abort_at > 0) begin
            for (int i = 0; i < abort_at; i++) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_data  = $urandom;
                @(negedge clock);
            end
            cfg_if.cfg_start = 1'b1;
            cfg_if.cfg_data  = $urandom;
            @(negedge clock);
            cfg_if.cfg_start = 1'b0;
            cfg_if.cfg_valid = 1'b0;
            check_eq("restart_busy", chk_t'(cfg_busy), chk_t'(1'b1));
            check_outputs("restart_hold");
        end
        for (int i = 0; i < int'(SEND_W); i++) begin
            if (gap_mode == 1) gaps = (i > 0) ? 1 : 0;
            else if (gap_mode == 2) gaps = int'($urandom_range(0, 2));
            else gaps = 0;
            repeat (gaps) begin
                cfg_if.cfg_valid = 1'b0;
                cfg_if.cfg_data  = $urandom;
                @(negedge clock);
            end
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_data  = img[i];
            if (bad_crc && i == int'(CRC_IDX)) begin
                cfg_if.cfg_data = img[i] ^ (32'h1 << $urandom_range(0, 31));
            end
            @(negedge clock);
            check_outputs("hold_during_load");
        end
        cfg_if.cfg_valid = 1'b0;
        check_eq("no_early_done", chk_t'(cfg_done), chk_t'(1'b0));
        if (bad_crc) begin
            check_eq("crc_err_set", chk_t'(cfg_err), chk_t'(1'b1));
            check_eq("crc_busy_drop", chk_t'(cfg_busy), chk_t'(1'b0));
            @(negedge clock);
            check_eq("crc_no_done", chk_t'(cfg_done), chk_t'(1'b0));
            check_eq("crc_err_sticky", chk_t'(cfg_err), chk_t'(1'b1));
            check_outputs("crc_hold");
        end else begin
            check_eq("busy_pre_commit", chk_t'(cfg_busy), chk_t'(1'b1));
            model_commit();
            @(negedge clock);
            check_eq("done_pulse", chk_t'(cfg_done), chk_t'(1'b1));
            check_outputs("commit");
            check_eq("busy_with_done", chk_t'(cfg_busy), chk_t'(1'b0));
            check_eq("ready_after_commit", chk_t'(cfg_if.cfg_ready), chk_t'(1'b0));
            check_eq("err_after_commit", chk_t'(cfg_err), chk_t'(1'b0));
        end
        @(negedge clock);
        check_eq("done_one_cycle", chk_t'(cfg_done), chk_t'(1'b0));
        check_eq("done_count", chk_t'(done_seen - base_done), chk_t'(bad_crc ? 1'b0 : 1'b1));
    endtask

    initial begin
        int base_done;
        cfg_if.cfg_start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        reset_n = 1'b0;
        exp_lut = '0;
        exp_sb  = '0;
        repeat (3) @(negedge clock);
        check_outputs("reset");
        check_eq("reset_ready", chk_t'(cfg_if.cfg_ready), chk_t'(1'b0));
        check_eq("reset_busy", chk_t'(cfg_busy), chk_t'(1'b0));
        check_eq("reset_done", chk_t'(cfg_done), chk_t'(1'b0));
        check_eq("reset_err", chk_t'(cfg_err), chk_t'(1'b0));
        reset_n = 1'b1;

        // Reference image from the bring-up plan
        for (int i = 0; i < int'(NUM_LUT); i++) img[LUT_BASE+i] = 32'h0000_1110 + i;
        for (int j = 0; j < int'(NUM_SB); j++) img[SB_BASE+j] = 32'hA5A5_0000 + j;
        img[FLAG_IDX] = 32'hF000_0000;
        seal_image();
        do_load(0, 0, 1'b0);
        check_eq("lut0_word", chk_t'(lut_cfg[0 +: LUT_CFG_W]), chk_t'(33'h1_0000_1110));
        check_eq("lut4_fsel", chk_t'(lut_cfg[4*LUT_CFG_W + 32]), chk_t'(1'b0));
        check_eq("sb6_word", chk_t'(sb_cfg[6*SB_CFG_W +: SB_CFG_W]), chk_t'(32'hA5A5_0006));

        do_load(1, 0, 1'b0);

        fill_random();
        do_load(0, 5, 1'b0);

        for (int n = 0; n < 6; n++) begin
            fill_random();
            do_load(2, 0, 1'b0);
        end

`ifdef CFG_CRC_EN
        fill_random();
        do_load(0, 0, 1'b1);
        fill_random();
        do_load(2, 0, 1'b0);
`endif

        // Reset in the middle of a load wipes committed state; stray valids afterwards are ignored
        base_done = done_seen;
        fill_random();
        @(negedge clock);
        cfg_if.cfg_start = 1'b1;
        @(negedge clock);
        cfg_if.cfg_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_data  = img[i];
            @(negedge clock);
        end
        reset_n = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        #1;
        exp_lut = '0;
        exp_sb  = '0;
        check_outputs("reset_mid_load");
        check_eq("reset_mid_busy", chk_t'(cfg_busy), chk_t'(1'b0));
        check_eq("reset_mid_ready", chk_t'(cfg_if.cfg_ready), chk_t'(1'b0));
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_data  = $urandom;
            @(negedge clock);
            check_eq("idle_ready", chk_t'(cfg_if.cfg_ready), chk_t'(1'b0));
            check_eq("idle_busy", chk_t'(cfg_busy), chk_t'(1'b0));
            check_outputs("idle_ignore");
        end
        cfg_if.cfg_valid = 1'b0;
        check_eq("idle_no_done", chk_t'(done_seen - base_done), chk_t'(1'b0));

        fill_random();
        do_load(2, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
